// File: rtl/dds_bank.sv
// Multi-channel DDS: per-channel phase accumulator, phase offset, shared-format sine ROM,
// amplitude scaling with saturation, and shadow/active registers committed by a global update.

module sine_rom (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         addr,
    output logic signed [15:0] data
);
    // Quarter-wave table round(32767*sin(2*pi*k/256)), k = 0..64; the negative half
    // is the bitwise complement of the positive half, so address 0xC0 reads 0x8000.
    logic [7:0]  fold_diff;
    logic [6:0]  idx;
    logic [14:0] quarter;
    logic [15:0] mag;

    assign fold_diff = 8'd128 - {1'b0, addr[6:0]};
    assign idx       = (addr[6:0] <= 7'd64) ? addr[6:0] : fold_diff[6:0];
    assign mag       = {1'b0, quarter};

    always_comb begin
        quarter = 15'd0;
        case (idx)
            7'd0:  quarter = 15'd0;     7'd1:  quarter = 15'd804;   7'd2:  quarter = 15'd1608;
            7'd3:  quarter = 15'd2410;  7'd4:  quarter = 15'd3212;  7'd5:  quarter = 15'd4011;
            7'd6:  quarter = 15'd4808;  7'd7:  quarter = 15'd5602;  7'd8:  quarter = 15'd6393;
            7'd9:  quarter = 15'd7179;  7'd10: quarter = 15'd7962;  7'd11: quarter = 15'd8739;
            7'd12: quarter = 15'd9512;  7'd13: quarter = 15'd10278; 7'd14: quarter = 15'd11039;
            7'd15: quarter = 15'd11793; 7'd16: quarter = 15'd12539; 7'd17: quarter = 15'd13279;
            7'd18: quarter = 15'd14010; 7'd19: quarter = 15'd14732; 7'd20: quarter = 15'd15446;
            7'd21: quarter = 15'd16151; 7'd22: quarter = 15'd16846; 7'd23: quarter = 15'd17530;
            7'd24: quarter = 15'd18204; 7'd25: quarter = 15'd18868; 7'd26: quarter = 15'd19519;
            7'd27: quarter = 15'd20159; 7'd28: quarter = 15'd20787; 7'd29: quarter = 15'd21403;
            7'd30: quarter = 15'd22005; 7'd31: quarter = 15'd22594; 7'd32: quarter = 15'd23170;
            7'd33: quarter = 15'd23731; 7'd34: quarter = 15'd24279; 7'd35: quarter = 15'd24811;
            7'd36: quarter = 15'd25329; 7'd37: quarter = 15'd25832; 7'd38: quarter = 15'd26319;
            7'd39: quarter = 15'd26790; 7'd40: quarter = 15'd27245; 7'd41: quarter = 15'd27683;
            7'd42: quarter = 15'd28105; 7'd43: quarter = 15'd28510; 7'd44: quarter = 15'd28898;
            7'd45: quarter = 15'd29268; 7'd46: quarter = 15'd29621; 7'd47: quarter = 15'd29956;
            7'd48: quarter = 15'd30273; 7'd49: quarter = 15'd30571; 7'd50: quarter = 15'd30852;
            7'd51: quarter = 15'd31113; 7'd52: quarter = 15'd31356; 7'd53: quarter = 15'd31580;
            7'd54: quarter = 15'd31785; 7'd55: quarter = 15'd31971; 7'd56: quarter = 15'd32137;
            7'd57: quarter = 15'd32285; 7'd58: quarter = 15'd32412; 7'd59: quarter = 15'd32521;
            7'd60: quarter = 15'd32609; 7'd61: quarter = 15'd32678; 7'd62: quarter = 15'd32728;
            7'd63: quarter = 15'd32757; 7'd64: quarter = 15'd32767;
            default: quarter = 15'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) data <= '0;
        else        data <= addr[7] ? ~mag : mag;
    end
endmodule

module dds_bank #(
    parameter  int NCH   = 4,
    parameter  int ACC_W = 32,
    parameter  int AMP_W = 17,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [1:0]         cfg_addr,
    input  logic [ACC_W-1:0]   cfg_data,
    input  logic               update,
    input  logic               sync_clear,
    output logic [NCH*16-1:0]  sine_out,
    output logic [NCH-1:0]     out_valid
);
    localparam int PW = AMP_W + 17;
    localparam logic [AMP_W-1:0]     AMP_UNITY = {2'b01, {(AMP_W-2){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX   = PW'(32767);
    localparam logic signed [PW-1:0] SAT_MIN   = PW'(-32768);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ACC_W-1:0]   sh_inc, act_inc, acc;
        logic [7:0]         sh_phase, act_phase, addr;
        logic [AMP_W-1:0]   sh_amp, act_amp, amp_d1;
        logic               sh_en, act_en, en_d1, en_d2, en_d3;
        logic               wr_hit;
        logic signed [15:0] rom_data, sample, sat;
        logic signed [PW-1:0] prod, scaled;

        assign wr_hit = cfg_we && (cfg_ch == CH_W'(c));

        // NOTE: non-blocking assignments mean an update coinciding with a write copies
        // the pre-write shadow value, while the write still lands in the shadow register.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sh_inc  <= '0;  sh_phase  <= '0;  sh_amp  <= AMP_UNITY;  sh_en  <= 1'b0;
                act_inc <= '0;  act_phase <= '0;  act_amp <= AMP_UNITY;  act_en <= 1'b0;
            end else begin
                if (wr_hit) begin
                    case (cfg_addr)
                        2'd0: sh_inc   <= cfg_data;
                        2'd1: sh_phase <= cfg_data[7:0];
                        2'd2: sh_amp   <= AMP_W'(cfg_data);
                        2'd3: sh_en    <= cfg_data[0];
                        default: ;
                    endcase
                end
                if (update) begin
                    act_inc <= sh_inc;  act_phase <= sh_phase;
                    act_amp <= sh_amp;  act_en    <= sh_en;
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset)                     acc <= '0;
            else if (sync_clear || !act_en) acc <= '0;
            else                            acc <= acc + act_inc;
        end

        assign addr = acc[ACC_W-1 -: 8] + act_phase;

        sine_rom u_rom (
            .clock (clock),
            .reset (reset),
            .addr  (addr),
            .data  (rom_data)
        );

        // Amplitude and enable travel with the ROM sample so a retune stays coherent.
        assign scaled = prod >>> (AMP_W - 2);

        always_comb begin
            sat = scaled[15:0];
            if (scaled > SAT_MAX)      sat = 16'sh7FFF;
            else if (scaled < SAT_MIN) sat = 16'sh8000;
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                amp_d1 <= '0;  en_d1 <= 1'b0;  en_d2 <= 1'b0;  en_d3 <= 1'b0;
                prod   <= '0;  sample <= '0;
            end else begin
                amp_d1 <= act_amp;
                en_d1  <= act_en;
                prod   <= PW'(rom_data) * PW'($signed({1'b0, amp_d1}));
                en_d2  <= en_d1;
                en_d3  <= en_d2;
                sample <= en_d2 ? sat : 16'sh0000;
            end
        end

        assign sine_out[16*c +: 16] = sample;
        assign out_valid[c]         = en_d3;
    end
endmodule

// File: tb/tb_dds_bank.sv
// Directed bench for dds_bank: expected samples are hand-computed from the sine table
// (rom[1]=804, rom[2]=1608, rom[0x40]=0x7FFF, rom[0xC0]=0x8000, rom[0xFF]=-805).

module tb_dds_bank;
    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        update;
    logic        sync_clear;
    logic [63:0] sine_out;
    logic [3:0]  out_valid;

    int n_tests  = 0;
    int n_failed = 0;

    dds_bank #(.NCH(4), .ACC_W(32), .AMP_W(17)) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .update     (update),
        .sync_clear (sync_clear),
        .sine_out   (sine_out),
        .out_valid  (out_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ch_out(input int c);
        return sine_out[16*c +: 16];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_data = d;
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_update(input logic with_clear);
        update = 1'b1; sync_clear = with_clear;
        @(negedge clock);
        update = 1'b0; sync_clear = 1'b0;
    endtask

    task automatic pulse_clear();
        sync_clear = 1'b1;
        @(negedge clock);
        sync_clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_data = '0;
        update = 1'b0; sync_clear = 1'b0;
        step(3);
        check("reset_sine", sine_out, 64'h0);
        check("reset_valid", {60'h0, out_valid}, 64'h0);
        reset = 1'b1;
        step(2);

        // Basic tone on channel 0
        cfg_write(2'd0, 2'd0, 32'h0100_0000);
        cfg_write(2'd0, 2'd3, 32'h1);
        pulse_update(1'b0);
        step(2);
        check("tone_valid_early", {60'h0, out_valid}, 64'h0);
        step(1);
        check("tone_s0", {48'h0, ch_out(0)}, 64'h0000);
        check("tone_valid", {60'h0, out_valid}, 64'h1);
        check("tone_others", {16'h0, sine_out[63:16]}, 64'h0);
        step(1); check("tone_s1", {48'h0, ch_out(0)}, 64'h0324);
        step(1); check("tone_s2", {48'h0, ch_out(0)}, 64'h0648);
        step(1); check("tone_s3", {48'h0, ch_out(0)}, 64'h096A);

        // Phase offset on channel 1, and 3-cycle latency of a phase change
        cfg_write(2'd1, 2'd1, 32'h40);
        cfg_write(2'd1, 2'd3, 32'h1);
        pulse_update(1'b0);
        step(3); check("phase_40", {48'h0, ch_out(1)}, 64'h7FFF);
        cfg_write(2'd1, 2'd1, 32'h00);
        pulse_update(1'b0);
        step(2); check("phase_hold", {48'h0, ch_out(1)}, 64'h7FFF);
        step(1); check("phase_change", {48'h0, ch_out(1)}, 64'h0000);

        // Amplitude scaling and saturation
        cfg_write(2'd1, 2'd1, 32'h40);
        cfg_write(2'd1, 2'd2, 32'h4000);
        pulse_update(1'b0);
        step(3); check("amp_half_pos", {48'h0, ch_out(1)}, 64'h3FFF);
        cfg_write(2'd1, 2'd2, 32'h1FFFF);
        pulse_update(1'b0);
        step(3); check("sat_pos", {48'h0, ch_out(1)}, 64'h7FFF);
        cfg_write(2'd1, 2'd1, 32'hC0);
        step(4); check("shadow_only", {48'h0, ch_out(1)}, 64'h7FFF);
        pulse_update(1'b0);
        step(3); check("sat_neg", {48'h0, ch_out(1)}, 64'h8000);
        cfg_write(2'd1, 2'd2, 32'h4000);
        pulse_update(1'b0);
        step(3); check("amp_half_neg", {48'h0, ch_out(1)}, 64'hC000);
        cfg_write(2'd1, 2'd1, 32'hFF);
        pulse_update(1'b0);
        step(3); check("amp_floor", {48'h0, ch_out(1)}, 64'hFE6D);

        // Accumulator wrap on channel 2, address wrap on channel 3
        cfg_write(2'd2, 2'd0, 32'hFFFF_FFFF);
        cfg_write(2'd2, 2'd3, 32'h1);
        cfg_write(2'd3, 2'd0, 32'h8000_0000);
        cfg_write(2'd3, 2'd1, 32'hC0);
        cfg_write(2'd3, 2'd3, 32'h1);
        pulse_update(1'b0);
        step(3);
        check("wrap_ch2_a0", {48'h0, ch_out(2)}, 64'h0000);
        check("wrap_ch3_c0", {48'h0, ch_out(3)}, 64'h8000);
        check("all_valid", {60'h0, out_valid}, 64'hF);
        step(1);
        check("wrap_ch2_ff", {48'h0, ch_out(2)}, 64'hFCDB);
        check("wrap_ch3_40", {48'h0, ch_out(3)}, 64'h7FFF);
        step(1);
        check("wrap_ch2_hold", {48'h0, ch_out(2)}, 64'hFCDB);
        check("wrap_ch3_back", {48'h0, ch_out(3)}, 64'h8000);

        // Write and update on the same edge keep the old increment; sync_clear aligns all
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd0; cfg_data = 32'h0200_0000;
        update = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0; update = 1'b0;
        pulse_clear();
        step(3); check("clear_align0", sine_out, 64'h8000_0000_FE6D_0000);
        step(1); check("clear_align1", sine_out, 64'h7FFF_FCDB_FE6D_0324);
        pulse_update(1'b1);
        step(3); check("newinc_s0", {48'h0, ch_out(0)}, 64'h0000);
        step(1); check("newinc_s1", {48'h0, ch_out(0)}, 64'h0648);

        // Disable channel 2
        cfg_write(2'd2, 2'd3, 32'h0);
        pulse_update(1'b0);
        step(2); check("dis_valid_hold", {63'h0, out_valid[2]}, 64'h1);
        step(1);
        check("dis_valid", {63'h0, out_valid[2]}, 64'h0);
        check("dis_sine", {48'h0, ch_out(2)}, 64'h0);

        // Asynchronous reset mid-stream
        #2 reset = 1'b0;
        #1;
        check("async_rst_sine", sine_out, 64'h0);
        check("async_rst_valid", {60'h0, out_valid}, 64'h0);
        step(1);
        reset = 1'b1;
        step(10);
        check("post_rst_sine", sine_out, 64'h0);
        check("post_rst_valid", {60'h0, out_valid}, 64'h0);
        cfg_write(2'd0, 2'd3, 32'h1);
        pulse_update(1'b0);
        step(3);
        check("restart_valid", {60'h0, out_valid}, 64'h1);
        check("restart_s0", {48'h0, ch_out(0)}, 64'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule
